// File: rtl/contrast_pkg.sv
// Shared sizing and state encoding for the contrast curve controller.
package contrast_pkg;
    localparam int DATA_W    = 8;
    localparam int LUT_DEPTH = 1 << DATA_W;
    localparam int LATENCY   = 2;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;
endpackage

// File: rtl/contrast_curve_ctrl_if.sv
// Configuration bus of the contrast curve controller: shadow-bank writes and commit.
interface contrast_curve_ctrl_if #(
    parameter int DATA_W = contrast_pkg::DATA_W
);
    logic              cfg_wr_en;
    logic [DATA_W-1:0] cfg_wr_addr;
    logic [DATA_W-1:0] cfg_wr_data;
    logic              cfg_wr_ready;
    logic              cfg_commit;

    modport master (
        output cfg_wr_en,
        output cfg_wr_addr,
        output cfg_wr_data,
        output cfg_commit,
        input  cfg_wr_ready
    );

    modport slave (
        input  cfg_wr_en,
        input  cfg_wr_addr,
        input  cfg_wr_data,
        input  cfg_commit,
        output cfg_wr_ready
    );
endinterface

// File: rtl/curve_lut_ram.sv
// Simple dual-port curve RAM holding both banks; the bank index is the address MSB.
module curve_lut_ram #(
    parameter int  DATA_W = contrast_pkg::DATA_W,
    parameter int  DEPTH  = 2 * contrast_pkg::LUT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_all_banks,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    // wr_all_banks ignores the bank bit so initialisation fills both tables at once.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_all_banks) begin
                mem[{1'b0, wr_addr[ADDR_W-2:0]}] <= wr_data;
                mem[{1'b1, wr_addr[ADDR_W-2:0]}] <= wr_data;
            end else begin
                mem[wr_addr] <= wr_data;
            end
        end
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/contrast_curve_ctrl.sv
// Double-buffered gray-level curve mapper; the lookup bank swaps only at frame start.
module contrast_curve_ctrl #(
    parameter int DATA_W  = contrast_pkg::DATA_W,
    parameter int LATENCY = contrast_pkg::LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 per_img_vsync,
    input  logic                 per_img_href,
    input  logic [DATA_W-1:0]    per_img_gray,
    output logic                 post_img_vsync,
    output logic                 post_img_href,
    output logic [DATA_W-1:0]    post_img_gray,
    contrast_curve_ctrl_if.slave cfg,
    output logic                 active_bank,
    output logic                 swap_pulse
);
    import contrast_pkg::*;

    localparam int RAM_DEPTH = 2 * (1 << DATA_W);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] init_cnt;
    logic              init_mode;
    logic              wr_ready;
    logic              frame_start;
    logic              do_swap;
    logic              lookup_bank;

    logic [LATENCY-1:0] vsync_dly;
    logic [LATENCY-1:0] href_dly;
    logic [DATA_W-1:0]  gray_d1;
    logic               bypass_d1;
    logic [DATA_W-1:0]  lut_q;

    logic              ram_wr_en;
    logic [DATA_W:0]   ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W:0]   ram_rd_addr;

    assign init_mode   = (state == INIT);
    assign frame_start = per_img_vsync & ~vsync_dly[0];

    // The pixel on the swap cycle already reads the incoming bank, so a whole frame sees one table.
    assign lookup_bank = active_bank ^ do_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_cnt    <= '0;
            active_bank <= 1'b0;
            swap_pulse  <= 1'b0;
        end else begin
            state       <= next_state;
            if (init_mode) begin
                init_cnt <= init_cnt + 1'b1;
            end
            active_bank <= active_bank ^ do_swap;
            swap_pulse  <= do_swap;
        end
    end

    always_comb begin
        next_state = state;
        do_swap    = 1'b0;
        wr_ready   = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == '1) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                wr_ready = 1'b1;
                if (cfg.cfg_commit) begin
                    if (frame_start) begin
                        do_swap = 1'b1;
                    end else begin
                        next_state = PEND;
                    end
                end
            end
            PEND: begin
                if (frame_start) begin
                    do_swap    = 1'b1;
                    next_state = RUN;
                end
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    assign cfg.cfg_wr_ready = wr_ready;

    assign ram_wr_en   = init_mode | (wr_ready & cfg.cfg_wr_en);
    assign ram_wr_addr = init_mode ? {1'b0, init_cnt} : {~active_bank, cfg.cfg_wr_addr};
    assign ram_wr_data = init_mode ? init_cnt : cfg.cfg_wr_data;
    assign ram_rd_addr = {lookup_bank, per_img_gray};

    curve_lut_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_DEPTH)
    ) u_lut (
        .clk          (clk),
        .wr_en        (ram_wr_en),
        .wr_all_banks (init_mode),
        .wr_addr      (ram_wr_addr),
        .wr_data      (ram_wr_data),
        .rd_addr      (ram_rd_addr),
        .rd_data      (lut_q)
    );

    // Stage 1 is the RAM read; stage 2 picks bypass or table value and blanks outside href.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_dly     <= '0;
            href_dly      <= '0;
            gray_d1       <= '0;
            bypass_d1     <= 1'b0;
            post_img_gray <= '0;
        end else begin
            vsync_dly     <= {vsync_dly[LATENCY-2:0], per_img_vsync};
            href_dly      <= {href_dly[LATENCY-2:0], per_img_href};
            gray_d1       <= per_img_gray;
            bypass_d1     <= init_mode;
            post_img_gray <= href_dly[0] ? (bypass_d1 ? gray_d1 : lut_q) : '0;
        end
    end

    assign post_img_vsync = vsync_dly[LATENCY-1];
    assign post_img_href  = href_dly[LATENCY-1];
endmodule
